// File: rtl/predictor_update_scheduler.sv
// Purpose: sweeps the 2-bit predictor table to weakly-not-taken, then serialises ROB/BU outcome updates.
// Latency: an accepted update is issued on the edge after acceptance (one table write per cycle).
// Backpressure: readies drop when the FIFO lacks room (BU needs two slots if ROB is also requesting) or on clear.
module predictor_update_scheduler #(
  parameter int LOCAL_WIDTH = 12,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                               clockIn,
  input  logic                               resetIn,
  input  logic                               clearIn,
  input  logic                               robValid,
  input  logic [31:0]                        robInstr,
  input  logic                               robTaken,
  output logic                               robReady,
  input  logic                               buValid,
  input  logic [31:0]                        buInstr,
  input  logic                               buTaken,
  output logic                               buReady,
  output logic                               initValid,
  output logic [LOCAL_WIDTH-1:0]             initIndex,
  output logic                               updateValid,
  output logic [31:0]                        updateInstr,
  output logic                               updateTaken,
  output logic                               predictReady,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pendingCount
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic [LOCAL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   init_valid_q, init_valid_d;
  logic [LOCAL_WIDTH-1:0] init_index_q, init_index_d;
  logic                   update_valid_q, update_valid_d;
  logic [31:0]            update_instr_q, update_instr_d;
  logic                   update_taken_q, update_taken_d;
  logic                   predict_ready_q, predict_ready_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  // Each entry is {taken, instr}.
  logic [32:0]            mem_q [QUEUE_DEPTH];
  logic [32:0]            mem_d [QUEUE_DEPTH];

  logic [CW-1:0] free;
  logic          run;
  logic          rob_push;
  logic          bu_push;
  logic          pop;

  // Free space excludes this edge's pop, so a full FIFO never accepts even while draining.
  assign run      = (state_q == ST_RUN);
  assign free     = CW'(QUEUE_DEPTH) - count_q;
  assign robReady = run && !clearIn && (free >= CW'(1));
  assign buReady  = run && !clearIn && (free >= (robValid ? CW'(2) : CW'(1)));
  assign rob_push = robValid && robReady;
  assign bu_push  = buValid && buReady;
  assign pop      = run && !clearIn && (count_q != '0);

  // Next-state: clear overrides everything, INIT sweeps the table, RUN moves the update FIFO.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    init_valid_d    = 1'b0;
    init_index_d    = init_index_q;
    update_valid_d  = 1'b0;
    update_instr_d  = update_instr_q;
    update_taken_d  = update_taken_q;
    predict_ready_d = predict_ready_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    mem_d           = mem_q;

    if (clearIn) begin
      state_d         = ST_INIT;
      cnt_d           = '0;
      init_index_d    = '0;
      predict_ready_d = 1'b0;
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      count_d         = '0;
    end else if (state_q == ST_INIT) begin
      // The last sweep write was registered on the previous edge; the counter has already wrapped.
      if (init_valid_q && (init_index_q == {LOCAL_WIDTH{1'b1}})) begin
        state_d         = ST_RUN;
        predict_ready_d = 1'b1;
      end else begin
        init_valid_d = 1'b1;
        init_index_d = cnt_q;
        cnt_d        = cnt_q + 1'b1;
      end
    end else begin
      if (pop) begin
        update_valid_d                  = 1'b1;
        {update_taken_d, update_instr_d} = mem_q[rd_ptr_q];
        rd_ptr_d                        = rd_ptr_q + 1'b1;
      end
      // ROB is written first so it drains ahead of a same-edge BU request.
      if (rob_push) begin
        mem_d[wr_ptr_q] = {robTaken, robInstr};
      end
      if (bu_push) begin
        mem_d[wr_ptr_q + PW'(rob_push)] = {buTaken, buInstr};
      end
      wr_ptr_d = wr_ptr_q + PW'(rob_push) + PW'(bu_push);
      count_d  = count_q + CW'(rob_push) + CW'(bu_push) - CW'(pop);
    end
  end

  // State and output registers with immediate reset.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state_q         <= ST_INIT;
      cnt_q           <= '0;
      init_valid_q    <= 1'b0;
      init_index_q    <= '0;
      update_valid_q  <= 1'b0;
      update_instr_q  <= '0;
      update_taken_q  <= 1'b0;
      predict_ready_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      mem_q           <= '{default: '0};
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      init_valid_q    <= init_valid_d;
      init_index_q    <= init_index_d;
      update_valid_q  <= update_valid_d;
      update_instr_q  <= update_instr_d;
      update_taken_q  <= update_taken_d;
      predict_ready_q <= predict_ready_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      mem_q           <= mem_d;
    end
  end

  assign initValid    = init_valid_q;
  assign initIndex    = init_index_q;
  assign updateValid  = update_valid_q;
  assign updateInstr  = update_instr_q;
  assign updateTaken  = update_taken_q;
  assign predictReady = predict_ready_q;
  assign pendingCount = count_q;

endmodule

// File: tb/tb_predictor_update_scheduler.sv
// Bench for predictor_update_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_predictor_update_scheduler;

  localparam int LW   = 3;
  localparam int QD   = 4;
  localparam int NENT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        rv = 1'b0, rt = 1'b0, bv = 1'b0, bt = 1'b0;
  logic [31:0] ri = '0, bi = '0;

  logic          rr, br, iv, uv, ut, pr;
  logic [LW-1:0] ii;
  logic [31:0]   ui;
  logic [2:0]    pc;

  predictor_update_scheduler #(.LOCAL_WIDTH(LW), .QUEUE_DEPTH(QD)) dut (
    .clockIn(clk), .resetIn(rst), .clearIn(clr),
    .robValid(rv), .robInstr(ri), .robTaken(rt), .robReady(rr),
    .buValid(bv), .buInstr(bi), .buTaken(bt), .buReady(br),
    .initValid(iv), .initIndex(ii),
    .updateValid(uv), .updateInstr(ui), .updateTaken(ut),
    .predictReady(pr), .pendingCount(pc)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit          m_run = 0, m_iv = 0, m_uv = 0, m_ut = 0, m_pr = 0;
  int          m_sweep = 0, m_ii = 0;
  logic [31:0] m_ui = '0;
  logic [32:0] m_q[$];
  int          m_sz;
  bit          m_ra, m_ba;
  bit          exp_rr, exp_br;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_iv = 0; m_uv = 0; m_ut = 0; m_pr = 0;
      m_sweep = 0; m_ii = 0; m_ui = '0;
      m_q.delete();
    end else if (clr) begin
      m_run = 0; m_iv = 0; m_uv = 0; m_pr = 0; m_sweep = 0;
      m_q.delete();
    end else if (!m_run) begin
      m_uv = 0;
      if (m_sweep < NENT) begin
        m_iv = 1; m_ii = m_sweep; m_sweep++;
      end else begin
        m_iv = 0; m_pr = 1; m_run = 1;
      end
    end else begin
      m_sz = m_q.size();
      m_ra = rv && (QD - m_sz >= 1);
      m_ba = bv && (QD - m_sz >= (rv ? 2 : 1));
      if (m_sz > 0) begin
        {m_ut, m_ui} = m_q.pop_front();
        m_uv = 1;
      end else begin
        m_uv = 0;
      end
      if (m_ra) m_q.push_back({rt, ri});
      if (m_ba) m_q.push_back({bt, bi});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    exp_rr = !rst && m_run && !clr && (QD - m_q.size() >= 1);
    exp_br = !rst && m_run && !clr && (QD - m_q.size() >= (rv ? 2 : 1));
    chk("mdl initValid", 32'(iv), 32'(m_iv));
    if (m_iv) chk("mdl initIndex", 32'(ii), 32'(m_ii));
    chk("mdl updateValid", 32'(uv), 32'(m_uv));
    if (m_uv) begin
      chk("mdl updateInstr", ui, m_ui);
      chk("mdl updateTaken", 32'(ut), 32'(m_ut));
    end
    chk("mdl predictReady", 32'(pr), 32'(m_pr));
    chk("mdl pendingCount", 32'(pc), 32'(m_q.size()));
    chk("mdl robReady", 32'(rr), 32'(exp_rr));
    chk("mdl buReady", 32'(br), 32'(exp_br));
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_checks(input string tag);
    for (int k = 0; k < NENT; k++) begin
      cyc();
      chk({tag, " initValid"}, 32'(iv), 32'd1);
      chk({tag, " initIndex"}, 32'(ii), 32'(k));
      chk({tag, " updateValid"}, 32'(uv), 32'd0);
      chk({tag, " predictReady"}, 32'(pr), 32'd0);
    end
    cyc();
    chk({tag, " end initValid"}, 32'(iv), 32'd0);
    chk({tag, " end predictReady"}, 32'(pr), 32'd1);
  endtask

  initial begin
    // Reset state: readies held low even with requests present.
    rst = 1'b1;
    cyc();
    cyc();
    rv = 1'b1; bv = 1'b1;
    #1;
    chk("rst robReady", 32'(rr), 32'd0);
    chk("rst buReady", 32'(br), 32'd0);
    chk("rst initValid", 32'(iv), 32'd0);
    chk("rst pendingCount", 32'(pc), 32'd0);
    rv = 1'b0; bv = 1'b0;
    rst = 1'b0;

    // 1. Init sweep 0..7, then RUN with both readies up.
    sweep_checks("t1");
    #1;
    chk("t1 robReady", 32'(rr), 32'd1);
    chk("t1 buReady", 32'(br), 32'd1);

    // 2. Single ROB update: issued on the edge after acceptance, one cycle wide.
    rv = 1'b1; ri = 32'h104; rt = 1'b1;
    cyc();
    rv = 1'b0;
    chk("t2 accept updateValid", 32'(uv), 32'd0);
    chk("t2 accept pending", 32'(pc), 32'd1);
    cyc();
    chk("t2 updateValid", 32'(uv), 32'd1);
    chk("t2 updateInstr", ui, 32'h104);
    chk("t2 updateTaken", 32'(ut), 32'd1);
    cyc();
    chk("t2 after updateValid", 32'(uv), 32'd0);

    // 3. Same-edge ROB and BU into an empty FIFO: ROB drains first.
    rv = 1'b1; ri = 32'h10; rt = 1'b0;
    bv = 1'b1; bi = 32'h20; bt = 1'b1;
    #1;
    chk("t3 robReady", 32'(rr), 32'd1);
    chk("t3 buReady", 32'(br), 32'd1);
    cyc();
    rv = 1'b0; bv = 1'b0;
    chk("t3 pending", 32'(pc), 32'd2);
    cyc();
    chk("t3 first valid", 32'(uv), 32'd1);
    chk("t3 first instr", ui, 32'h10);
    chk("t3 first taken", 32'(ut), 32'd0);
    cyc();
    chk("t3 second valid", 32'(uv), 32'd1);
    chk("t3 second instr", ui, 32'h20);
    chk("t3 second taken", 32'(ut), 32'd1);
    cyc();
    chk("t3 idle valid", 32'(uv), 32'd0);

    // 4. Both requesters held high: occupancy settles at 3 with BU starved of its second slot.
    for (int i = 0; i < 20; i++) begin
      rv = 1'b1; ri = 32'h1000 + 32'(i * 8); rt = 1'(i % 2);
      bv = 1'b1; bi = 32'h2000 + 32'(i * 8); bt = 1'((i + 1) % 2);
      cyc();
      chk("t4 pending bound", 32'(pc <= 3'd4), 32'd1);
    end
    chk("t4 steady pending", 32'(pc), 32'd3);
    #1;
    chk("t4 steady robReady", 32'(rr), 32'd1);
    chk("t4 steady buReady", 32'(br), 32'd0);

    // 5. Clear with 3 queued: flush, no further updates, full re-sweep.
    rv = 1'b0; bv = 1'b0; clr = 1'b1;
    #1;
    chk("t5 clr robReady", 32'(rr), 32'd0);
    chk("t5 clr buReady", 32'(br), 32'd0);
    cyc();
    clr = 1'b0;
    chk("t5 pending", 32'(pc), 32'd0);
    chk("t5 updateValid", 32'(uv), 32'd0);
    chk("t5 predictReady", 32'(pr), 32'd0);
    chk("t5 initValid", 32'(iv), 32'd0);
    sweep_checks("t5");

    // Clear held high keeps the sweep parked.
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold initValid", 32'(iv), 32'd0);
      chk("hold predictReady", 32'(pr), 32'd0);
    end
    clr = 1'b0;

    // 6. Async reset mid-sweep at index 5.
    for (int k = 0; k < 6; k++) cyc();
    chk("t6 pre index", 32'(ii), 32'd5);
    #1;
    rst = 1'b1;
    #1;
    chk("t6 initValid", 32'(iv), 32'd0);
    chk("t6 initIndex", 32'(ii), 32'd0);
    chk("t6 updateValid", 32'(uv), 32'd0);
    chk("t6 updateInstr", ui, 32'd0);
    chk("t6 updateTaken", 32'(ut), 32'd0);
    chk("t6 predictReady", 32'(pr), 32'd0);
    chk("t6 pendingCount", 32'(pc), 32'd0);
    chk("t6 robReady", 32'(rr), 32'd0);
    chk("t6 buReady", 32'(br), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    sweep_checks("t6");

    // Mixed traffic left to the every-cycle model comparison.
    for (int i = 0; i < 16; i++) begin
      rv = 1'((i % 3) != 0); ri = 32'hA000 + 32'(i * 4); rt = 1'((i / 2) % 2);
      bv = 1'(i % 2);        bi = 32'hB000 + 32'(i * 4); bt = 1'(i % 3 == 1);
      cyc();
    end
    rv = 1'b0; bv = 1'b0;
    repeat (6) cyc();
    chk("drain pending", 32'(pc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
